// File: rtl/counter_seek_ctrl.sv
// Seek controller: steps an external 4-bit up/down counter one enable pulse at a
// time until its output matches a captured target, or gives up after MAX_STEPS.
module counter_seek_ctrl #(
  parameter int unsigned MAX_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] target,
  input  logic [3:0] count,
  output logic       up,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [4:0] steps
);

  localparam logic [4:0] MAX_S = 5'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, CMP, MOVE, SETTLE, FIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] tgt_q, tgt_d;
  logic       up_q, up_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;
  logic [4:0] steps_q, steps_d;
  logic [1:0] rdy_q, rdy_d;

  // Starts are held off until reset release has passed through two flops.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    up_d      = up_q;
    en_d      = 1'b0;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    steps_d   = steps_q;
    rdy_d     = {rdy_q[0], 1'b1};
    case (state_q)
      IDLE: begin
        if (start && rdy_q[1]) begin
          tgt_d     = target;
          steps_d   = 5'd0;
          timeout_d = 1'b0;
          state_d   = CMP;
        end
      end
      CMP: begin
        if (count == tgt_q) begin
          state_d = FIN;
        end else if (steps_q == MAX_S) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          up_d    = (count < tgt_q);
          en_d    = 1'b1;
          steps_d = (steps_q == 5'd31) ? steps_q : steps_q + 5'd1;
          state_d = MOVE;
        end
      end
      MOVE:    state_d = SETTLE;
      SETTLE:  state_d = CMP;
      FIN: begin
        done_d  = ~timeout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tgt_q     <= 4'd0;
      up_q      <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      steps_q   <= 5'd0;
      rdy_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      up_q      <= up_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      steps_q   <= steps_d;
      rdy_q     <= rdy_d;
    end
  end

  assign up      = up_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign steps   = steps_q;

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// Bench for counter_seek_ctrl: two instances (default MAX_STEPS and MAX_STEPS=4),
// each driving its own counter model, checked from a vector table and a distance model.
module tb_counter_seek_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] target = 4'd0;
  logic       ld = 1'b1, frz = 1'b0, sel4 = 1'b0;
  logic [3:0] ld_val = 4'd0;
  logic [3:0] cnt0, cnt1;
  logic       up0, en0, busy0, done0, tmo0;
  logic       up1, en1, busy1, done1, tmo1;
  logic [4:0] steps0, steps1;
  logic       s_up, s_en, s_busy, s_done, s_tmo;
  logic [4:0] s_steps;

  int checks = 0;
  int errors = 0;

  counter_seek_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .count(cnt0),
    .up(up0), .en(en0), .busy(busy0), .done(done0), .timeout(tmo0), .steps(steps0)
  );

  counter_seek_ctrl #(.MAX_STEPS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .target(target), .count(cnt1),
    .up(up1), .en(en1), .busy(busy1), .done(done1), .timeout(tmo1), .steps(steps1)
  );

  always #5 clk = ~clk;

  // Counters attached to each controller; frz freezes both, ld preloads both.
  always @(posedge clk) begin
    if (ld) cnt0 <= ld_val;
    else if (en0 && !frz) cnt0 <= up0 ? cnt0 + 4'd1 : cnt0 - 4'd1;
    if (ld) cnt1 <= ld_val;
    else if (en1 && !frz) cnt1 <= up1 ? cnt1 + 4'd1 : cnt1 - 4'd1;
  end

  assign s_up    = sel4 ? up1    : up0;
  assign s_en    = sel4 ? en1    : en0;
  assign s_busy  = sel4 ? busy1  : busy0;
  assign s_done  = sel4 ? done1  : done0;
  assign s_tmo   = sel4 ? tmo1   : tmo0;
  assign s_steps = sel4 ? steps1 : steps0;

  typedef struct {
    bit       s4;
    bit [3:0] c0;
    bit [3:0] t;
    bit       fz;
    int       ex_p;
    int       ex_done;
    int       ex_steps;
    int       ex_tmo;
    int       ex_up;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 150) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 32'(busy0 | busy1), 0);
    @(posedge clk); #1;
  endtask

  // Seek outcome derived from the distance alone: d pulses if d fits the budget.
  function automatic void model(input int c0, input int t, input int m,
                                output int p, output int dn, output int st,
                                output int tm, output int u);
    int d;
    d = (t > c0) ? t - c0 : c0 - t;
    if (d <= m) begin p = d; dn = 2 + 3 * d; tm = 0; end
    else        begin p = m; dn = -1;        tm = 1; end
    st = p;
    u  = (d == 0) ? -1 : ((t > c0) ? 1 : 0);
  endfunction

  task automatic run_seek(input vec_t v, input bit poke, input string nm);
    int p, fd, nd, uerr, kmax;
    sel4 = v.s4; frz = v.fz;
    ld_val = v.c0; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    target = v.t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p = 0; fd = -1; nd = 0; uerr = 0;
    kmax = 3 * v.ex_p + 8;
    for (int k = 1; k <= kmax; k++) begin
      if (poke && k == 3) begin start = 1'b1; target = ~v.t; end
      if (poke && k == 4) begin start = 1'b0; target = v.t; end
      @(posedge clk); #1;
      if (s_en) begin
        p++;
        if (v.ex_up >= 0 && s_up !== v.ex_up[0]) uerr++;
      end
      if (s_done) begin nd++; if (fd < 0) fd = k; end
    end
    chk({nm, " pulses"}, p, v.ex_p);
    chk({nm, " done_at"}, fd, v.ex_done);
    chk({nm, " done_cnt"}, nd, (v.ex_done < 0) ? 0 : 1);
    chk({nm, " steps"}, 32'(s_steps), v.ex_steps);
    chk({nm, " timeout"}, 32'(s_tmo), v.ex_tmo);
    chk({nm, " busy_end"}, 32'(s_busy), 0);
    chk({nm, " up_dir"}, uerr, 0);
    wait_idle();
  endtask

  vec_t tbl[9];

  initial begin
    int p, dn, st, tm, u, n;
    vec_t v;

    //          s4  c0     t      fz  p   done st  tmo up
    tbl[0] = '{1'b0, 4'd5,  4'd5,  1'b0, 0,  2,  0,  0, -1};
    tbl[1] = '{1'b0, 4'd3,  4'd7,  1'b0, 4,  14, 4,  0,  1};
    tbl[2] = '{1'b0, 4'd15, 4'd0,  1'b0, 15, 47, 15, 0,  0};
    tbl[3] = '{1'b0, 4'd0,  4'd15, 1'b0, 15, 47, 15, 0,  1};
    tbl[4] = '{1'b1, 4'd2,  4'd9,  1'b1, 4,  -1, 4,  1,  1};
    tbl[5] = '{1'b1, 4'd8,  4'd8,  1'b0, 0,  2,  0,  0, -1};
    tbl[6] = '{1'b0, 4'd10, 4'd6,  1'b0, 4,  14, 4,  0,  0};
    tbl[7] = '{1'b1, 4'd1,  4'd5,  1'b0, 4,  14, 4,  0,  1};
    tbl[8] = '{1'b1, 4'd0,  4'd9,  1'b0, 4,  -1, 4,  1,  1};

    // Reset state before any clock edge.
    #1;
    chk("rst_outs0", 32'({up0, en0, busy0, done0, tmo0, steps0}), 0);
    chk("rst_outs1", 32'({up1, en1, busy1, done1, tmo1, steps1}), 0);

    // Start held across reset release: not accepted on the first two edges.
    repeat (3) @(posedge clk);
    #1;
    ld = 1'b0; target = 4'd0; start = 1'b1;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("sync_edge1_busy", 32'(busy0), 0);
    @(posedge clk); #1;
    chk("sync_edge2_busy", 32'(busy0), 0);
    n = 0;
    while (!busy0 && n < 4) begin @(posedge clk); #1; n++; end
    chk("sync_accept", 32'(busy0), 1);
    start = 1'b0;
    wait_idle();

    foreach (tbl[i]) run_seek(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Randomised seeks against the distance model, both budgets.
    for (int i = 0; i < 24; i++) begin
      v.s4 = i[0];
      v.c0 = 4'($urandom_range(0, 15));
      v.t  = 4'($urandom_range(0, 15));
      v.fz = 1'b0;
      model(v.c0, v.t, v.s4 ? 4 : 16, p, dn, st, tm, u);
      v.ex_p = p; v.ex_done = dn; v.ex_steps = st; v.ex_tmo = tm; v.ex_up = u;
      run_seek(v, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset during a MOVE cycle aborts without waiting for a clock.
    sel4 = 1'b0; frz = 1'b0;
    ld_val = 4'd0; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0; target = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!en0 && n < 10) begin @(posedge clk); #1; n++; end
    chk("mid_rst_saw_en", 32'(en0), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en_async", 32'(en0), 0);
    chk("mid_rst_busy_async", 32'(busy0), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done0 || tmo0) n++;
    end
    chk("mid_rst_no_pulse", n, 0);
    chk("mid_rst_outs", 32'({up0, en0, busy0, done0, tmo0, steps0}), 0);

    // Start pulses while busy are ignored; seek finishes to the captured target.
    v = '{1'b0, 4'd4, 4'd8, 1'b0, 4, 14, 4, 0, 1};
    run_seek(v, 1'b1, "ignore_start");

    // Start held high through FIN re-accepts on the first IDLE cycle.
    sel4 = 1'b0;
    ld_val = 4'd4; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0; target = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held_done", 32'(done0), 1);
    chk("held_idle_gap", 32'(busy0), 0);
    @(posedge clk); #1;
    chk("held_reaccept", 32'(busy0), 1);
    start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
